// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
//
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per clock, so a normal operation takes 32
// iterations. Results follow RISC-V rules, including divide-by-zero and the
// signed overflow case.
//
// Ports
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   dividend    in   rs1 operand, sampled only at the accept edge
//   divisor     in   rs2 operand, sampled only at the accept edge
//   DIVop       in   operation select, sampled only at the accept edge
//   div_valid   in   start request, held by control until div_ready
//   div_result  out  quotient or remainder, registered, holds after div_ready
//   div_ready   out  one-cycle completion pulse
//   busy        out  high while an operation is in CALC or DONE
//
// Operation encoding (DIVop, width DIV_OP_WIDTH = 2):
//   DIV_OP_DIV = 2'b00, DIV_OP_DIVU = 2'b01, DIV_OP_REM = 2'b10,
//   DIV_OP_REMU = 2'b11
//
// Optional feature macro: DIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed overflow are resolved at the
//   accept edge and skip the iteration loop (div_ready one cycle later).
//   When undefined, every operation runs all 32 iterations.
//
// State table
//   state  | meaning
//   IDLE   | waiting for div_valid; accepts and loads operands
//   CALC   | one restoring-division iteration per clock, 32 in total
//   DONE   | div_ready pulse, then back to IDLE unconditionally
// -----------------------------------------------------------------------------
module divider_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [1:0]  DIVop,
  input  logic        div_valid,
  output logic [31:0] div_result,
  output logic        div_ready,
  output logic        busy
);

  localparam int         DIV_OP_WIDTH = 2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                  r_state;
  logic [DIV_OP_WIDTH-1:0] r_op;
  logic                    r_neg_a;    // dividend negative (signed ops only)
  logic                    r_neg_b;    // divisor negative (signed ops only)
  logic                    r_b_zero;   // divisor was zero at accept
  logic [32:0]             r_rem;      // partial remainder
  logic [31:0]             r_quo;      // dividend magnitude shifting out, quotient shifting in
  logic [31:0]             r_dvsr;     // divisor magnitude
  logic [5:0]              r_cnt;      // remaining iterations

  // ---------------------------------------------------------------------------
  // Accept-side decode: operand signs and magnitudes
  // ---------------------------------------------------------------------------
  logic        w_signed_op;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  always_comb begin
    w_signed_op = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
    w_a_neg     = w_signed_op && dividend[31];
    w_b_neg     = w_signed_op && divisor[31];
    // -2^31 negates to itself, which is the correct unsigned magnitude.
    w_a_mag     = w_a_neg ? (32'd0 - dividend) : dividend;
    w_b_mag     = w_b_neg ? (32'd0 - divisor)  : divisor;
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath: shift {rem, quo} left, trial subtract, restore on borrow
  // ---------------------------------------------------------------------------
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fit;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  always_comb begin
    w_shift   = {r_rem[31:0], r_quo[31]};
    w_diff    = w_shift - {1'b0, r_dvsr};
    w_fit     = ~w_diff[32];
    w_rem_nxt = w_fit ? w_diff : w_shift;
    w_quo_nxt = {r_quo[30:0], w_fit};
  end

  // ---------------------------------------------------------------------------
  // Sign correction of the final iteration's values
  // ---------------------------------------------------------------------------
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_final;

  always_comb begin
    // Divide-by-zero must keep the all-ones quotient, i.e. -1, unnegated.
    if ((r_op == DIV_OP_DIV) && (r_neg_a ^ r_neg_b) && !r_b_zero)
      w_quo_fix = 32'd0 - w_quo_nxt;
    else
      w_quo_fix = w_quo_nxt;

    if ((r_op == DIV_OP_REM) && r_neg_a)
      w_rem_fix = 32'd0 - w_rem_nxt[31:0];
    else
      w_rem_fix = w_rem_nxt[31:0];

    if ((r_op == DIV_OP_DIV) || (r_op == DIV_OP_DIVU))
      w_final = w_quo_fix;
    else
      w_final = w_rem_fix;
  end

`ifdef DIV_FAST_SPECIAL_EN
  // ---------------------------------------------------------------------------
  // Special cases resolved directly from the live operands in IDLE
  // ---------------------------------------------------------------------------
  logic        w_div_zero;
  logic        w_overflow;
  logic        w_special;
  logic [31:0] w_special_res;

  always_comb begin
    w_div_zero = (divisor == 32'd0);
    w_overflow = w_signed_op && (dividend == 32'h8000_0000) &&
                 (divisor == 32'hFFFF_FFFF);
    w_special  = w_div_zero || w_overflow;

    w_special_res = 32'd0;
    if (w_div_zero) begin
      if ((DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_DIVU))
        w_special_res = 32'hFFFF_FFFF;
      else
        w_special_res = dividend;
    end else if (w_overflow) begin
      if (DIVop == DIV_OP_DIV)
        w_special_res = 32'h8000_0000;
      else
        w_special_res = 32'd0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_op       <= DIV_OP_DIV;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_rem      <= 33'd0;
      r_quo      <= 32'd0;
      r_dvsr     <= 32'd0;
      r_cnt      <= 6'd0;
      div_result <= 32'd0;
      div_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          div_ready <= 1'b0;
          if (div_valid) begin
            r_op     <= DIVop;
            r_neg_a  <= w_a_neg;
            r_neg_b  <= w_b_neg;
            r_b_zero <= (divisor == 32'd0);
            r_rem    <= 33'd0;
            r_quo    <= w_a_mag;
            r_dvsr   <= w_b_mag;
            r_cnt    <= 6'd32;
            busy     <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
            // Shortcut enters DONE with div_ready still low, so the pulse
            // lands one cycle after the accept edge.
            if (w_special) begin
              div_result <= w_special_res;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end

        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            div_result <= w_final;
            div_ready  <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_DONE: begin
          if (div_ready) begin
            div_ready <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            div_ready <= 1'b1;
          end
        end

        default: begin
          div_ready <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_unit
//
// Self-checking bench for divider_unit. Expected results come from a plain
// arithmetic model of the RV32M division rules; expected latency is 32 cycles,
// or 1 cycle for divide-by-zero / signed overflow when DIV_FAST_SPECIAL_EN is
// defined for the build.
// -----------------------------------------------------------------------------
module tb_divider_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [1:0]  DIVop = 2'b00;
  logic        div_valid = 1'b0;
  logic [31:0] div_result;
  logic        div_ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  divider_unit u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .dividend   (dividend),
    .divisor    (divisor),
    .DIVop      (DIVop),
    .div_valid  (div_valid),
    .div_result (div_result),
    .div_ready  (div_ready),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M reference semantics
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    bit special;
    special = (b == 0) ||
              ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return special ? SPECIAL_LAT : 32;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // One complete operation: drive, scramble operands after accept, wait for the
  // pulse, check result, latency, pulse width and result hold.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          lat;
    logic [31:0] exp;
    exp = ref_div(op, a, b);
    @(negedge clk);
    DIVop = op; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
    DIVop = 2'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (!div_ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    div_valid = 1'b0;
    chk({tag, "/res"}, div_result, exp);
    chk({tag, "/lat"}, 32'(lat), 32'(ref_lat(op, a, b)));
    @(posedge clk); #1;
    chk({tag, "/pulse"}, {31'd0, div_ready}, 32'd0);
    chk({tag, "/hold"}, div_result, exp);
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          last;
    bit          seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    // Reset state
    #1 resetn = 1'b0;
    #2;
    chk("rst/ready", {31'd0, div_ready}, 32'd0);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/result", div_result, 32'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, "remu_100_7");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(OP_DIVU, 32'd5, 32'd0, "divu_by0");
    run_op(OP_DIV,  32'hFFFF_FFFB, 32'd0, "div_by0");
    run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, "rem_by0");
    run_op(OP_REMU, 32'hFFFF_FFFB, 32'd0, "remu_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

    // Reset in the middle of CALC
    @(negedge clk);
    DIVop = OP_DIV; dividend = 32'd1000; divisor = 32'hFFFF_FFFD; div_valid = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst/ready", {31'd0, div_ready}, 32'd0);
    chk("midrst/busy", {31'd0, busy}, 32'd0);
    chk("midrst/result", div_result, 32'd0);
    dividend = $urandom; divisor = $urandom; DIVop = OP_DIVU;
    repeat (3) @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready || busy) seen = 1'b1;
    end
    chk("midrst/no_activity", {31'd0, seen}, 32'd0);
    chk("midrst/result_after", div_result, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, "divu_9_3");

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "rand");
    end

    // Back-to-back with div_valid held high; operands stay stable from the
    // pulse until the next accept, then are scrambled.
    last = 0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom | 32'd1;
    if (b == 32'hFFFF_FFFF) b = 32'd3;
    @(negedge clk);
    DIVop = op; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    dividend = $urandom; divisor = $urandom; DIVop = 2'($urandom);
    for (int i = 0; i < 6; i++) begin
      lat = 0;
      while (!div_ready && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("b2b/res", div_result, ref_div(op, a, b));
      if (i > 0)
        chk("b2b/gap", {31'd0, ((cyc - last) == 33) || ((cyc - last) == 34)}, 32'd1);
      last = cyc;
      if (i < 5) begin
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom | 32'd1;
        if (b == 32'hFFFF_FFFF) b = 32'd3;
        DIVop = op; dividend = a; divisor = b;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dividend = $urandom; divisor = $urandom; DIVop = 2'($urandom);
      end else begin
        div_valid = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b/idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
